alu_exec_stage: RTL

Execute stage directly downstream of the operand shifter: consumes the first operand (Rn) and the shifted/rotated second operand, evaluates the ARM data-processing opcode and condition field, and holds the architectural NZCV flags register. The result sits in a single-entry output register with a valid/ready handshake toward writeback, so a stalled writeback back-pressures issue.

---
 rtl/alu_exec_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// ARM data-processing execute stage: condition check, 33-bit adder/logic unit,
// NZCV flags register and a single-entry valid/ready output register.
module alu_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [3:0]  alu_op,
  input  logic        set_flags,
  input  logic [3:0]  cond,
  input  logic [3:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  out_rd,
  output logic        reg_write,
  output logic [3:0]  flags
);

  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_pass;
  logic        is_test;
  logic        is_arith;
  logic        accept;
  logic        flag_we;
  logic [31:0] add_x, add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic [31:0] logic_res;
  logic [31:0] alu_res;
  logic        res_c, res_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign is_test  = (alu_op[3:2] == 2'b10);

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c & !flag_z;
      4'b1001: cond_pass = !flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Subtract forms feed the inverted operand; reverse forms swap operands first.
  always_comb begin
    add_x    = srca;
    add_y    = srcb;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (alu_op)
      4'b0010, 4'b1010: begin add_y = ~srcb; add_cin = 1'b1; end
      4'b0011:          begin add_x = srcb; add_y = ~srca; add_cin = 1'b1; end
      4'b0100, 4'b1011: add_cin = 1'b0;
      4'b0101:          add_cin = flag_c;
      4'b0110:          begin add_y = ~srcb; add_cin = flag_c; end
      4'b0111:          begin add_x = srcb; add_y = ~srca; add_cin = flag_c; end
      default:          is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  always_comb begin
    logic_res = 32'd0;
    case (alu_op)
      4'b0000, 4'b1000: logic_res = srca & srcb;
      4'b0001, 4'b1001: logic_res = srca ^ srcb;
      4'b1100:          logic_res = srca | srcb;
      4'b1101:          logic_res = srcb;
      4'b1110:          logic_res = srca & ~srcb;
      4'b1111:          logic_res = ~srcb;
      default:          logic_res = 32'd0;
    endcase
  end

  // Logical ops keep C and V since the shifter carry-out is not available here.
  assign alu_res = is_arith ? sum[31:0] : logic_res;
  assign res_c   = is_arith ? sum[32] : flag_c;
  assign res_v   = is_arith ? ((add_x[31] == add_y[31]) & (sum[31] != add_x[31])) : flag_v;
  assign flag_we = accept & cond_pass & (set_flags | is_test);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      out_rd    <= 4'd0;
      reg_write <= 1'b0;
      flags     <= 4'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        out_rd    <= rd;
        reg_write <= cond_pass & !is_test;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (flag_we) begin
        flags <= {alu_res[31], (alu_res == 32'd0), res_c, res_v};
      end
    end
  end

endmodule
